// File: rtl/nanosoc_ahb_pkg.sv
// AHB-Lite encodings shared by nanosoc bus managers, plus the IMEM loader state type.
package nanosoc_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_RUN,
        LD_DRAIN,
        LD_DONE,
        LD_ABORT
    } loader_state_e;

    function automatic logic is_nonseq(input logic [1:0] trans);
        return trans == HTRANS_NONSEQ;
    endfunction

endpackage

// File: rtl/nanosoc_imem_loader.sv
// AHB-Lite write-only manager that streams words to consecutive word addresses,
// used to preload instruction memory before the CPU is released.
module nanosoc_imem_loader
    import nanosoc_ahb_pkg::*;
#(
    parameter int         SYS_ADDR_W = 32,
    parameter int         SYS_DATA_W = 32,
    parameter int         CNT_W      = 16,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    input  logic [SYS_ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]      word_count,
    input  logic                  in_valid,
    input  logic [SYS_DATA_W-1:0] in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_W-1:0]      words_done,
    output logic [SYS_ADDR_W-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HWRITE,
    output logic                  HMASTLOCK,
    output logic [SYS_DATA_W-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    loader_state_e         state_q, state_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [SYS_ADDR_W-1:0] haddr_q, haddr_d;
    logic [SYS_ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [SYS_DATA_W-1:0] hwdata_q, hwdata_d;
    logic [SYS_DATA_W-1:0] ap_data_q, ap_data_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [CNT_W-1:0]      words_done_q, words_done_d;
    logic                  err_q, err_d;
    logic                  dphase_q, dphase_d;
    logic                  accept;

    always_comb begin
        state_d      = state_q;
        htrans_d     = htrans_q;
        haddr_d      = haddr_q;
        next_addr_d  = next_addr_q;
        hwdata_d     = hwdata_q;
        ap_data_d    = ap_data_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        err_d        = err_q;
        dphase_d     = dphase_q;
        in_ready     = 1'b0;
        accept       = 1'b0;

        // dphase_q marks a write data phase in flight; it retires on HREADY, counted only if OKAY.
        if (HREADY && dphase_q && !HRESP) begin
            words_done_d = words_done_q + CNT_W'(1);
        end

        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (word_count == '0) begin
                        state_d = LD_DONE;
                    end else begin
                        state_d      = LD_RUN;
                        next_addr_d  = base_addr & ~SYS_ADDR_W'(3);
                        remaining_d  = word_count;
                        words_done_d = '0;
                    end
                end
            end

            LD_RUN, LD_DRAIN: begin
                in_ready = (state_q == LD_RUN) && HREADY && !HRESP && (remaining_q != '0);
                accept   = in_valid && in_ready;
                if (HRESP && !HREADY) begin
                    // First ERROR cycle: retract the pending address phase, its word is dropped.
                    state_d  = LD_ABORT;
                    htrans_d = HTRANS_IDLE;
                    err_d    = 1'b1;
                end else begin
                    if (HREADY) begin
                        dphase_d = is_nonseq(htrans_q);
                        if (is_nonseq(htrans_q)) begin
                            hwdata_d = ap_data_q;
                        end
                        htrans_d = HTRANS_IDLE;
                        if (accept) begin
                            htrans_d    = HTRANS_NONSEQ;
                            haddr_d     = next_addr_q;
                            ap_data_d   = in_data;
                            next_addr_d = next_addr_q + SYS_ADDR_W'(4);
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                    end
                    if (state_q == LD_RUN) begin
                        if (remaining_d == '0) begin
                            state_d = LD_DRAIN;
                        end
                    end else if (!is_nonseq(htrans_q) && (!dphase_q || HREADY)) begin
                        state_d = LD_DONE;
                    end
                end
            end

            LD_ABORT: begin
                if (HREADY) begin
                    dphase_d = 1'b0;
                end
                if (HRESP && HREADY) begin
                    state_d = LD_DONE;
                end
            end

            LD_DONE: begin
                dphase_d = 1'b0;
                state_d  = LD_IDLE;
            end

            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= LD_IDLE;
            htrans_q     <= HTRANS_IDLE;
            haddr_q      <= '0;
            next_addr_q  <= '0;
            hwdata_q     <= '0;
            ap_data_q    <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            err_q        <= 1'b0;
            dphase_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            htrans_q     <= htrans_d;
            haddr_q      <= haddr_d;
            next_addr_q  <= next_addr_d;
            hwdata_q     <= hwdata_d;
            ap_data_q    <= ap_data_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            err_q        <= err_d;
            dphase_q     <= dphase_d;
        end
    end

    assign busy       = (state_q == LD_RUN) || (state_q == LD_DRAIN) || (state_q == LD_ABORT);
    assign done       = (state_q == LD_DONE);
    assign err        = err_q;
    assign words_done = words_done_q;
    assign HADDR      = haddr_q;
    assign HTRANS     = htrans_q;
    assign HWDATA     = hwdata_q;
    assign HSIZE      = HSIZE_WORD;
    assign HBURST     = HBURST_SINGLE;
    assign HPROT      = HPROT_VAL;
    assign HWRITE     = 1'b1;
    assign HMASTLOCK  = 1'b0;

endmodule

// File: tb/tb_nanosoc_imem_loader.sv
// Randomised bench for nanosoc_imem_loader: a transfer-level reference model predicts
// every AHB beat, handshake and status output, with a scripted subordinate driving HREADY/HRESP.
module tb_nanosoc_imem_loader;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic        HCLK       = 1'b0;
    logic        HRESET     = 1'b1;
    logic        start      = 1'b0;
    logic [31:0] base_addr  = '0;
    logic [15:0] word_count = '0;
    logic        in_valid   = 1'b0;
    logic [31:0] in_data    = '0;
    logic        in_ready, busy, done, err;
    logic [15:0] words_done;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE, HMASTLOCK;
    logic        HREADY     = 1'b1;
    logic        HRESP      = 1'b0;

    nanosoc_imem_loader dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .err(err),
        .words_done(words_done), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: loader activity, pipelined AHB beat contents and status.
    typedef enum {M_IDLE, M_ACTIVE, M_DONE} mode_e;
    mode_e       m_mode = M_IDLE;
    bit          m_aborted, m_err, m_dp;
    int          m_remaining, m_accepted, m_words_done;
    logic [1:0]  m_htrans = T_IDLE;
    logic [31:0] m_haddr = '0, m_hwdata = '0, m_apdata = '0, m_base = '0;

    // Stream source and subordinate behaviour.
    logic [31:0] stream[$];
    int          sent, valid_mode;
    bit          hold_valid, tog, seen_done;
    int          ws_min, ws_max, ws_left, err_beat, dbeat, err_step;
    int          cyc, last_ok_cyc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, check, then advance the model to the next edge.
    task automatic applyStimulus(input bit rst, input bit st, input logic [31:0] base, input logic [15:0] cnt);
        bit          acc, exp_ready;
        int          rem0;
        mode_e       n_mode;
        logic [1:0]  n_htrans;
        logic [31:0] n_haddr, n_hwdata, n_apdata;
        bit          n_dp;
        @(negedge HCLK);
        cyc++;
        HRESET = rst; start = st; base_addr = base; word_count = cnt;
        if (m_dp && dbeat == err_beat) begin
            HRESP = 1'b1; HREADY = (err_step == 1);
        end else if (m_dp && ws_left > 0) begin
            HRESP = 1'b0; HREADY = 1'b0;
        end else begin
            HRESP = 1'b0; HREADY = 1'b1;
        end
        if (!rst && sent < stream.size()) begin
            if (hold_valid || valid_mode == 0) in_valid = 1'b1;
            else if (valid_mode == 1) begin in_valid = tog; tog = !tog; end
            else in_valid = 1'($urandom_range(0, 1));
            in_data = stream[sent];
        end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        #1;
        exp_ready = (m_mode == M_ACTIVE) && !m_aborted && (m_remaining > 0) && HREADY && !HRESP;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("HTRANS", 32'(HTRANS), 32'(m_htrans));
        checkOutput("HADDR", HADDR, m_haddr);
        checkOutput("HWDATA", HWDATA, m_hwdata);
        checkOutput("busy", 32'(busy), 32'(m_mode == M_ACTIVE));
        checkOutput("done", 32'(done), 32'(m_mode == M_DONE));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("words_done", 32'(words_done), 32'(m_words_done));
        checkOutput("ctrl", 32'({HSIZE, HBURST, HPROT, HWRITE, HMASTLOCK}),
                    32'({3'b010, 3'b000, 4'b0011, 1'b1, 1'b0}));
        if (done === 1'b1) seen_done = 1'b1;
        acc        = in_valid && exp_ready;
        hold_valid = in_valid && !acc;

        if (rst) begin
            m_mode = M_IDLE; m_aborted = 0; m_err = 0; m_dp = 0;
            m_remaining = 0; m_accepted = 0; m_words_done = 0;
            m_htrans = T_IDLE; m_haddr = '0; m_hwdata = '0; m_apdata = '0;
            ws_left = 0; dbeat = 0; err_step = 0; hold_valid = 0;
        end else begin
            rem0     = m_remaining;
            n_mode   = m_mode;
            n_htrans = m_htrans;
            n_haddr  = m_haddr;
            n_hwdata = m_hwdata;
            n_apdata = m_apdata;
            n_dp     = m_dp;
            if (m_dp && HREADY && !HRESP) begin
                m_words_done++;
                last_ok_cyc = cyc;
            end
            if (m_dp && HREADY) begin dbeat++; err_step = 0; end
            else if (m_dp && dbeat == err_beat) err_step = 1;
            else if (m_dp) ws_left--;
            if (HREADY) begin
                n_dp     = (m_htrans == T_NONSEQ);
                n_htrans = T_IDLE;
                if (m_htrans == T_NONSEQ) n_hwdata = m_apdata;
                if (n_dp) ws_left = int'($urandom_range(ws_min, ws_max));
            end
            if (acc) begin
                n_htrans = T_NONSEQ;
                n_haddr  = m_base + 32'(4 * m_accepted);
                n_apdata = stream[sent];
                m_accepted++; m_remaining--; sent++;
            end
            case (m_mode)
                M_IDLE: if (st) begin
                    m_err = 0;
                    if (cnt == 16'd0) n_mode = M_DONE;
                    else begin
                        n_mode = M_ACTIVE; m_remaining = int'(cnt); m_accepted = 0;
                        m_words_done = 0; m_aborted = 0; m_base = base & 32'hFFFF_FFFC;
                    end
                end
                M_ACTIVE: begin
                    if (m_aborted) begin
                        if (HRESP && HREADY) n_mode = M_DONE;
                    end else if (HRESP && !HREADY) begin
                        m_aborted = 1; m_err = 1; n_htrans = T_IDLE;
                    end else if (rem0 == 0 && m_htrans == T_IDLE && (!m_dp || HREADY)) begin
                        n_mode = M_DONE;
                    end
                end
                default: n_mode = M_IDLE;
            endcase
            m_mode = n_mode; m_htrans = n_htrans; m_haddr = n_haddr;
            m_hwdata = n_hwdata; m_apdata = n_apdata; m_dp = n_dp;
        end
    endtask

    task automatic runTransfer(input string name, input logic [31:0] base, input int cnt,
                               input int vmode, input int wmin, input int wmax, input int ebeat);
        int exp_words;
        stream.delete();
        for (int i = 0; i < cnt; i++) stream.push_back($urandom);
        sent = 0; hold_valid = 0; tog = 1; valid_mode = vmode; ws_min = wmin; ws_max = wmax;
        err_beat = ebeat; dbeat = 0; err_step = 0; seen_done = 0; last_ok_cyc = -1;
        exp_words = (ebeat >= 0 && ebeat < cnt) ? ebeat : cnt;
        $display("[TB] %s: base %h count %0d", name, base, cnt);
        applyStimulus(0, 1, base, 16'(cnt));
        for (int i = 0; i < 1000 && !seen_done; i++) applyStimulus(0, (i == 1), $urandom, 16'd7);
        checkOutput({name, " completes"}, 32'(seen_done), 32'd1);
        if (cnt > 0) checkOutput({name, " words_done"}, 32'(words_done), 32'(exp_words));
        checkOutput({name, " err"}, 32'(err), 32'(exp_words != cnt));
        if (exp_words == cnt && cnt > 0) checkOutput({name, " done_latency"}, 32'(cyc), 32'(last_ok_cyc + 1));
        applyStimulus(0, 0, '0, '0);
    endtask

    initial begin
        err_beat = -1;
        HRESET   = 1'b1;
        repeat (2) @(posedge HCLK);
        applyStimulus(0, 0, '0, '0);
        checkOutput("reset HADDR", HADDR, 32'h0);
        checkOutput("reset HTRANS", 32'(HTRANS), 32'(T_IDLE));

        runTransfer("zero_wait", 32'h2000_0000, 4, 0, 0, 0, -1);
        runTransfer("two_wait", 32'h2000_0000, 4, 0, 2, 2, -1);
        runTransfer("valid_gaps", 32'h2000_0040, 3, 1, 0, 0, -1);
        runTransfer("error_beat2", 32'h2000_0000, 4, 0, 0, 0, 1);
        runTransfer("count_zero", 32'h2000_0000, 0, 0, 0, 0, -1);
        runTransfer("addr_wrap", 32'hFFFF_FFFC, 2, 0, 0, 0, -1);
        runTransfer("misaligned", 32'h2000_0103, 3, 2, 0, 1, -1);

        $display("[TB] reset during RUN");
        stream.delete();
        for (int i = 0; i < 8; i++) stream.push_back($urandom);
        sent = 0; hold_valid = 0; valid_mode = 0; ws_min = 0; ws_max = 1; err_beat = -1; dbeat = 0;
        applyStimulus(0, 1, 32'h2000_0200, 16'd8);
        repeat (3) applyStimulus(0, 0, '0, '0);
        applyStimulus(1, 0, '0, '0);
        applyStimulus(0, 0, '0, '0);
        checkOutput("post-reset busy", 32'(busy), 32'd0);
        checkOutput("post-reset HADDR", HADDR, 32'h0);
        checkOutput("post-reset words_done", 32'(words_done), 32'd0);
        runTransfer("after_reset", 32'h2000_0000, 4, 0, 0, 0, -1);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, 12));
            runTransfer("random", $urandom, n, 2, 0, 3, int'($urandom_range(0, n)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/nanosoc_imem_loader.md
Name: nanosoc_imem_loader

Overview:
- AHB-Lite manager that writes a stream of 32-bit words to consecutive word addresses. Typical target is the IMEM region at 0x20000000.
- Used by the debug/boot path to preload instruction memory before CPU release.
- Sits on a spare manager port of the nanosoc bus matrix. Drives address/control phases and consumes HREADY/HRESP from the subordinates.
- Address and data phases of successive beats are pipelined.

Parameters:
- SYS_ADDR_W, 32, system address width.
- SYS_DATA_W, 32, system data width; only 32 is supported.
- CNT_W, 16, width of the word-count and progress counters.
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (privileged data, non-cacheable, non-bufferable).

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  reset
- start  in  1  single-cycle command strobe; sampled only in IDLE
- base_addr  in  SYS_ADDR_W  first write address; bits [1:0] ignored
- word_count  in  CNT_W  number of words to write
- in_valid  in  1  stream word valid
- in_data  in  SYS_DATA_W  stream word
- in_ready  out  1  stream word accepted this cycle when in_valid=1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag; cleared by the next accepted start
- words_done  out  CNT_W  count of data phases completed with OKAY
- HADDR  out  SYS_ADDR_W  AHB address
- HTRANS  out  2  AHB transfer type
- HSIZE  out  3  fixed 3'b010
- HBURST  out  3  fixed 3'b000 (SINGLE)
- HPROT  out  4  HPROT_VAL
- HWRITE  out  1  fixed 1
- HMASTLOCK  out  1  fixed 0
- HWDATA  out  SYS_DATA_W  AHB write data
- HREADY  in  1  bus ready
- HRESP  in  1  bus response (1 = ERROR)

Interface decision: one clock, HCLK; reset HRESET is synchronous and active-high.

Behaviour:
- Reset values: HTRANS=IDLE, HADDR=0, HWDATA=0, busy=0, done=0, err=0, words_done=0, in_ready=0, state=IDLE.
- All AHB outputs are registered.
- States:
  - IDLE. start=1 with word_count=0 → DONE. start=1 with word_count≠0 → RUN; latch next_addr={base_addr[SYS_ADDR_W-1:2],2'b00}, remaining=word_count; clear err and words_done.
  - RUN. in_ready = HREADY & (remaining≠0) & ~HRESP.
    - On HREADY=1: HWDATA<=ap_data if the current HTRANS=NONSEQ.
    - If in_valid & in_ready: HTRANS<=NONSEQ, HADDR<=next_addr, ap_data<=in_data, next_addr+=4 (wraps modulo 2^SYS_ADDR_W), remaining-=1.
    - Otherwise HTRANS<=IDLE.
    - When remaining reaches 0 → DRAIN.
  - DRAIN. HTRANS<=IDLE at the next HREADY. Wait until no address or data phase is outstanding, then → DONE.
  - DONE. done=1 for one cycle, busy=0 → IDLE.
  - ABORT. Entered from RUN or DRAIN when HRESP=1 & HREADY=0 (first ERROR cycle). HTRANS<=IDLE immediately, cancelling any pending address phase; the cancelled word is lost and not counted. Set err=1. Wait for HRESP=1 & HREADY=1 → DONE.
- Latency: a word accepted in cycle N has its address phase in N+1. Its data phase starts at the first HREADY=1 at or after N+1. Zero-wait back-to-back throughput is 1 word/cycle.
- Wait states: while HREADY=0, HADDR/HTRANS/HWDATA hold and in_ready=0.
- words_done increments on each HREADY=1 & HRESP=0 that completes a write data phase.
- in_valid gaps produce IDLE beats. Ready is never withheld in anticipation.
- start while busy is ignored. word_count is sampled only at start.
- HRESET mid-operation: all state returns to reset values at the next edge. Any in-flight AHB transfer is abandoned; the system is reset together with the bus.

Decomposition:
- Package nanosoc_ahb_pkg: HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE encodings, and the loader state enum.
- No sub-module. FSM, address/count registers and the two data registers live in one module.

Test Plan:
- Base 0x20000000, count 4, in_valid held, zero-wait subordinate → NONSEQ to 0x20000000..0x2000000C on 4 consecutive cycles; HWDATA lags one cycle; done 1 cycle after the last data phase; words_done=4; err=0.
- Same transfer with 2 wait states per beat → HADDR/HWDATA stable during stalls, in_ready=0 while HREADY=0, all 4 words land, words_done=4.
- in_valid toggling 1,0,1,0 with count 3 → IDLE beats inserted, addresses still consecutive, done after 3 writes.
- ERROR on beat 2 of 4 (HRESP=1 for two cycles) → HTRANS=IDLE from the second error cycle, err=1, words_done=1, done pulses, no further writes.
- count=0 start → done on the next cycle, no AHB activity. base 0xFFFFFFFC, count 2 → addresses 0xFFFFFFFC then 0x00000000.
- HRESET asserted in RUN → next cycle all outputs at reset values; a following start behaves normally.
